pu_input_packer: RTL and testbench
==================================

// Module: pu_input_packer
// PURPOSE
// - Upstream feeder for the inner-product PU: serves pu_rd_req/pu_rd_ready/pu_data_in from a scalar operand stream.
// - Packs NUM_PE operands per PU word. Zero-pads the unused lanes of the last word of each input row.
// - Buffers packed words in a small FIFO, so stream stalls and PU stalls are decoupled.
// PARAMETERS
// - OP_WIDTH    16  operand width in bits
// - NUM_PE      1   lanes per PU word; DATA_WIDTH = OP_WIDTH*NUM_PE
// - FIFO_DEPTH  8   packed-word FIFO depth; power of 2, >= 2
// - CFG_WIDTH   16  width of the row-size and row-count config fields
// PORTS
// - clk              in   1           single clock; all logic on posedge
// - reset_n          in   1           synchronous, active-low reset
// - start            in   1           1-cycle pulse; latches cfg_*; ignored unless IDLE
// - cfg_row_width    in   CFG_WIDTH   operands per row (input_width); must be >= 1
// - cfg_num_rows     in   CFG_WIDTH   rows = height*channels*batch; must be >= 1
// - s_valid          in   1           operand stream valid
// - s_ready          out  1           operand stream ready
// - s_data           in   OP_WIDTH    operand
// - pu_rd_req        in   1           PU pops one word
// - pu_rd_ready      out  1           FIFO holds at least one word
// - pu_data_in       out  DATA_WIDTH  packed word; lane i = bits [i*OP_WIDTH +: OP_WIDTH]
// - done             out  1           all words packed and popped; held until next start
// - underflow_err    out  1           sticky: pu_rd_req while FIFO empty; cleared by start/reset
// BEHAVIOUR
// - Reset (reset_n=0 at posedge):
//   - outputs: s_ready=0, pu_rd_ready=0, pu_data_in=0, done=0, underflow_err=0
//   - FIFO pointers, lane, column and row counters cleared; state=IDLE
//   - a reset mid-operation discards the partial pack and all FIFO contents
// - FSM states: IDLE -> PACK on start
//   - PACK -> DRAIN when the last operand of row cfg_num_rows-1 is accepted
//   - DRAIN -> DONE when FIFO is empty
//   - DONE -> PACK on start; done drops the cycle after start
// - Stream accept:
//   - handshake = s_valid & s_ready
//   - s_ready = (state==PACK) & ~fifo_full
//   - a pop in the same cycle does not unblock s_ready; the stall is conservative by one cycle
// - Packing:
//   - accepted operand -> lane reg[lane]; lane, col increment
//   - push when lane==NUM_PE-1 or col==cfg_row_width-1
//   - on push, lanes above the current lane are forced to 0
//   - lane resets to 0 on push; col wraps to 0 at row end and the row counter increments
//   - the pushed word includes the operand accepted that cycle
// - Words per row = ceil_a_by_b(cfg_row_width, NUM_PE). Total words = that * cfg_num_rows.
// - Lane order: first operand of a word in lane 0. No packed word straddles two rows.
// - Read side:
//   - pu_rd_ready = ~fifo_empty, registered from the FIFO count
//   - pu_rd_req with pu_rd_ready pops; pu_data_in is updated at that posedge (1-cycle latency)
//   - pu_data_in holds its value until the next pop
// - Underflow: pu_rd_req while empty sets underflow_err. No pop occurs and pu_data_in holds.
// - Simultaneous push and pop: allowed whenever the FIFO is neither empty-before-push nor full; count unchanged.
// - NUM_PE=1: every accepted operand pushes immediately; padding never applies.
// - start outside IDLE/DONE is ignored. Config is never re-sampled mid-frame.
// STRUCTURE
// - common.vh: ceil_a_by_b, clog2 macros/functions, the FSM state encodings (IDLE/PACK/DRAIN/DONE).
// - One sub-module: fifo (synchronous, DATA_WIDTH x FIFO_DEPTH, push/pop/full/empty/count).
// - The top level holds the FSM, lane/column/row counters, pack register and error flag.
// TESTING (OP_WIDTH=16; stream s_data = 0,1,2,... unless noted)
// - Padding: NUM_PE=4, row_width=6, rows=2 -> words {3,2,1,0}, {0,0,5,4}, {9,8,7,6}, {0,0,11,10}; then done=1.
// - Exact fit: NUM_PE=4, row_width=8, rows=1 -> {3,2,1,0}, {7,6,5,4}; no zero lanes.
// - Backpressure: FIFO_DEPTH=4, pu_rd_req=0 -> s_ready drops after 4 pushes; release -> all words in order, none lost.
// - Underflow: pu_rd_req=1 with FIFO empty -> underflow_err=1 (sticky), pu_data_in unchanged; cleared by the next start.
// - Reset mid-frame: reset_n=0 after 3 words are pushed -> all outputs 0, state IDLE; a new start replays from operand 0 correctly.
// - NUM_PE=1, row_width=3, rows=2 -> 6 words 0..5, one per operand; done after the last pop.

Source files
------------

// File: rtl/pu_input_packer_pkg.sv
// Shared types and helpers for the PU input packer.
package pu_input_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that stays legal (>= 1 bit) for single-entry ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pu_input_packer_fifo.sv
// Synchronous packed-word FIFO; full/empty derive from the registered count.
module pu_input_packer_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pu_input_packer.sv
// Packs a scalar operand stream into NUM_PE-lane PU words, zero-padding row tails.
module pu_input_packer
  import pu_input_packer_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CFG_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [CFG_WIDTH-1:0]         cfg_row_width,
  input  logic [CFG_WIDTH-1:0]         cfg_num_rows,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [OP_WIDTH-1:0]          s_data,
  input  logic                         pu_rd_req,
  output logic                         pu_rd_ready,
  output logic [OP_WIDTH*NUM_PE-1:0]   pu_data_in,
  output logic                         done,
  output logic                         underflow_err
);
  localparam int DATA_WIDTH = OP_WIDTH * NUM_PE;
  localparam int LW         = clog2_min1(NUM_PE);
  localparam int CW         = $clog2(FIFO_DEPTH);
  localparam logic [CFG_WIDTH-1:0] CFG_ONE = CFG_WIDTH'(1);

  pack_state_e state_q, state_d;

  logic [CFG_WIDTH-1:0] rw_q, rows_q, col_q, row_q;
  logic [LW-1:0]        lane_q;
  logic [NUM_PE-1:0][OP_WIDTH-1:0] pack_q, push_word;

  logic                  fifo_full, fifo_empty;
  logic [CW:0]           fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  logic start_acc, hs, last_lane, last_col, last_row, push_now, pop_ok;

  assign start_acc = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign s_ready   = (state_q == ST_PACK) & ~fifo_full;
  assign hs        = s_valid & s_ready;
  assign last_lane = (lane_q == LW'(NUM_PE - 1));
  assign last_col  = (col_q == rw_q - CFG_ONE);
  assign last_row  = (row_q == rows_q - CFG_ONE);
  assign push_now  = hs & (last_lane | last_col);
  assign pu_rd_ready = (fifo_count != '0);
  assign pop_ok    = pu_rd_req & pu_rd_ready;
  assign done      = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PACK;
      ST_PACK:  if (hs && last_col && last_row) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_PACK;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Config is captured only on an accepted start and held for the whole frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rw_q   <= '0;
      rows_q <= '0;
      lane_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (start_acc) begin
      rw_q   <= cfg_row_width;
      rows_q <= cfg_num_rows;
      lane_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (hs) begin
      lane_q <= push_now ? '0 : lane_q + 1'b1;
      if (last_col) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  pack_q <= '0;
    else if (hs)   pack_q[lane_q] <= s_data;
  end

  // Outgoing word: held lanes below, live operand at lane_q, zeros above.
  always_comb begin
    push_word = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (LW'(i) < lane_q)       push_word[i] = pack_q[i];
      else if (LW'(i) == lane_q) push_word[i] = s_data;
    end
  end

  pu_input_packer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_now),
    .push_data (push_word),
    .pop       (pop_ok),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)    pu_data_in <= '0;
    else if (pop_ok) pu_data_in <= fifo_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                       underflow_err <= 1'b0;
    else if (pu_rd_req && !pu_rd_ready) underflow_err <= 1'b1;
    else if (start_acc)                 underflow_err <= 1'b0;
  end

endmodule

// File: tb/tb_pu_input_packer.sv
// Directed + randomized checks of pu_input_packer against a row/word reference model.
module tb_pu_input_packer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // NUM_PE=4, FIFO_DEPTH=4 instance
  logic        start4, s_valid4, s_ready4, req4, rdy4, done4, uf4;
  logic [15:0] rw4, rows4, s_data4;
  logic [63:0] data4;
  // NUM_PE=1 instance
  logic        start1, s_valid1, s_ready1, req1, rdy1, done1, uf1;
  logic [15:0] rw1, rows1, s_data1, data1;

  pu_input_packer #(.OP_WIDTH(16), .NUM_PE(4), .FIFO_DEPTH(4), .CFG_WIDTH(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .cfg_row_width(rw4), .cfg_num_rows(rows4),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .pu_rd_req(req4),
    .pu_rd_ready(rdy4), .pu_data_in(data4), .done(done4), .underflow_err(uf4));

  pu_input_packer #(.OP_WIDTH(16), .NUM_PE(1), .FIFO_DEPTH(8), .CFG_WIDTH(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .cfg_row_width(rw1), .cfg_num_rows(rows1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .pu_rd_req(req1),
    .pu_rd_ready(rdy1), .pu_data_in(data1), .done(done1), .underflow_err(uf1));

  int checks = 0;
  int errors = 0;
  logic [15:0] ops [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < 64; i++) ops[i] = 16'(i);
  endtask

  // Expected words are built row by row in chunks of 4 operands, lane 0 first.
  task automatic run_frame(input int rw, input int rows, input bit rnd,
                           input int stall, input int exp_fill);
    logic [63:0] exp_q[$];
    logic [63:0] w;
    int idx, got, total, nwords, cyc;
    bit pend;
    total = rw * rows;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < rw; c += 4) begin
        w = '0;
        for (int l = 0; l < 4; l++)
          if (c + l < rw) w[l*16 +: 16] = ops[r*rw + c + l];
        exp_q.push_back(w);
      end
    nwords = exp_q.size();
    @(negedge clk);
    start4 = 1'b1; rw4 = 16'(rw); rows4 = 16'(rows);
    @(negedge clk);
    start4 = 1'b0; rw4 = 16'($urandom); rows4 = 16'($urandom);
    chk("done_after_start", done4, 0);
    chk("uf_after_start", uf4, 0);
    idx = 0; got = 0; pend = 1'b0; cyc = 0;
    forever begin
      if (pend) begin
        if (exp_q.size() == 0) chk("extra_word", data4, 64'hx);
        else begin
          w = exp_q.pop_front();
          chk("word", data4, w);
        end
        got++;
      end
      if (done4 === 1'b1 || cyc >= 3000) break;
      if (stall > 0 && cyc == stall) begin
        chk("fill_ops", 64'(idx), 64'(exp_fill));
        chk("fill_s_ready", s_ready4, 0);
        chk("fill_rd_ready", rdy4, 1);
      end
      s_valid4 = (idx < total) && (cyc < stall || !rnd || $urandom_range(0, 3) != 0);
      s_data4  = s_valid4 ? ops[idx] : 16'($urandom);
      if (s_valid4 && s_ready4) idx++;
      req4 = (cyc >= stall) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1) && rdy4;
      pend = req4;
      @(negedge clk);
      cyc++;
    end
    s_valid4 = 1'b0; req4 = 1'b0;
    chk("done", done4, 1);
    chk("word_count", 64'(got), 64'(nwords));
    chk("s_ready_in_done", s_ready4, 0);
  endtask

  initial begin
    int acc, got1;
    bit pend1;
    reset_n = 1'b0;
    start4 = 0; rw4 = 0; rows4 = 0; s_valid4 = 0; s_data4 = 0; req4 = 0;
    start1 = 0; rw1 = 0; rows1 = 0; s_valid1 = 0; s_data1 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready4, 0);
    chk("rst_rd_ready", rdy4, 0);
    chk("rst_data", data4, 0);
    chk("rst_done", done4, 0);
    chk("rst_uf", uf4, 0);
    chk("rst1_data", data1, 0);
    reset_n = 1'b1;

    // Padding: 6-wide rows, 2 rows
    fill_index();
    run_frame(6, 2, 1'b0, 0, 0);
    chk("pad_last_word", data4, 64'h0000_0000_000b_000a);

    // Exact fit
    run_frame(8, 1, 1'b0, 0, 0);

    // Underflow: read from empty FIFO, data must hold
    @(negedge clk); req4 = 1'b1;
    @(negedge clk); req4 = 1'b0;
    chk("uf_set", uf4, 1);
    chk("uf_data_hold", data4, 64'h0007_0006_0005_0004);
    @(negedge clk);
    chk("uf_sticky", uf4, 1);

    // Backpressure: 30 stalled cycles, 4-deep FIFO fills after 16 operands
    run_frame(8, 3, 1'b0, 30, 16);

    // Reset mid-frame after 3 words pushed
    @(negedge clk); start4 = 1'b1; rw4 = 16'd8; rows4 = 16'd2;
    @(negedge clk); start4 = 1'b0;
    acc = 0;
    for (int c = 0; c < 40 && acc < 12; c++) begin
      s_valid4 = 1'b1; s_data4 = ops[acc];
      if (s_ready4) acc++;
      @(negedge clk);
    end
    s_valid4 = 1'b0; req4 = 1'b1;
    @(negedge clk); req4 = 1'b1;
    req4 = 1'b0;
    chk("pre_reset_word", data4, 64'h0003_0002_0001_0000);
    @(negedge clk); req4 = 1'b1;
    @(negedge clk); req4 = 1'b0;
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("mid_rst_s_ready", s_ready4, 0);
    chk("mid_rst_rd_ready", rdy4, 0);
    chk("mid_rst_data", data4, 0);
    chk("mid_rst_done", done4, 0);
    chk("mid_rst_uf", uf4, 0);
    run_frame(6, 2, 1'b1, 0, 0);

    // Randomized frames
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) ops[i] = 16'($urandom);
      run_frame(int'($urandom_range(1, 9)), int'($urandom_range(1, 3)), 1'b1, 0, 0);
    end

    // NUM_PE=1: one word per operand
    @(negedge clk); start1 = 1'b1; rw1 = 16'd3; rows1 = 16'd2;
    @(negedge clk); start1 = 1'b0;
    acc = 0; got1 = 0; pend1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (pend1) begin
        chk("pe1_word", 64'(data1), 64'(got1));
        got1++;
      end
      if (done1 === 1'b1) break;
      s_valid1 = (acc < 6);
      s_data1  = 16'(acc);
      if (s_valid1 && s_ready1) acc++;
      req1 = rdy1 && ($urandom_range(0, 1) != 0);
      pend1 = req1;
      @(negedge clk);
    end
    s_valid1 = 1'b0; req1 = 1'b0;
    chk("pe1_done", done1, 1);
    chk("pe1_count", 64'(got1), 64'd6);
    chk("pe1_uf", uf1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
